// File: rtl/cache_line_responder_pkg.sv
// Shared types and request encodings for the cache line responder.
package cache_line_responder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BEATS = 2'd2,
        ACK   = 2'd3
    } linersp_state_t;

    localparam logic [1:0] RW_NONE  = 2'b00;
    localparam logic [1:0] RW_WB    = 2'b01;
    localparam logic [1:0] RW_FETCH = 2'b10;
    localparam logic [1:0] RW_BOTH  = 2'b11;

endpackage

// File: rtl/cache_line_responder_if.sv
// Cache line bus between an I$/D$ (master) and the memory-side responder (slave).
interface cache_line_responder_if #(
    parameter int PA_BITS = 34,
    parameter int LINELEN = 512,
    parameter int WORDLEN = 64,
    parameter int LOGBWPL = 3
);
    logic [1:0]         CacheBusRW;
    logic [PA_BITS-1:0] CacheBusAdr;
    logic [WORDLEN-1:0] ReadDataWord;
    logic               CacheBusAck;
    logic               SelBusBeat;
    logic [LOGBWPL-1:0] BeatCount;
    logic [LINELEN-1:0] FetchBuffer;
    logic               ProtocolErr;

    modport master (
        output CacheBusRW, CacheBusAdr, ReadDataWord,
        input  CacheBusAck, SelBusBeat, BeatCount, FetchBuffer, ProtocolErr
    );

    modport slave (
        input  CacheBusRW, CacheBusAdr, ReadDataWord,
        output CacheBusAck, SelBusBeat, BeatCount, FetchBuffer, ProtocolErr
    );
endinterface

// File: rtl/cache_line_responder_line_word_mem.sv
// Line-organised word store: synchronous write, asynchronous read, addressed by {line, beat}.
module line_word_mem #(
    parameter int AW      = 11,
    parameter int WORDLEN = 64
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      addr,
    input  logic [WORDLEN-1:0] wdata,
    output logic [WORDLEN-1:0] rdata
);
    localparam int DEPTH = 2 ** AW;

    logic [WORDLEN-1:0] mem_r [DEPTH];

    // Contents are deliberately not reset so a reset mid-writeback leaves the line as written so far.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/cache_line_responder.sv
// Memory-side responder serving cache line fetches and writebacks as fixed-length word bursts.
module cache_line_responder
    import cache_line_responder_pkg::*;
#(
    parameter int PA_BITS      = 34,
    parameter int LINELEN      = 512,
    parameter int WORDLEN      = 64,
    parameter int NUMLINES_MEM = 256,
    parameter int LATENCY      = 2,
    localparam int LOGBWPL     = $clog2(LINELEN / WORDLEN)
) (
    input logic                  clk,
    input logic                  reset,
    cache_line_responder_if.slave bus
);
    localparam int N         = LINELEN / WORDLEN;
    localparam int OFFSETLEN = $clog2(LINELEN / 8);
    localparam int IDXW      = $clog2(NUMLINES_MEM);

    linersp_state_t     state_q, state_d;
    logic               is_write_q, is_write_d;
    logic [IDXW-1:0]    line_q, line_d;
    logic [3:0]         wait_cnt_q, wait_cnt_d;
    logic [LOGBWPL-1:0] beat_q, beat_d;
    logic [LINELEN-1:0] fetch_buf_q, fetch_buf_d;
    logic               prot_err_q, prot_err_d;
    logic               mem_we_s;
    logic [WORDLEN-1:0] mem_rdata_s;
    logic               unused_adr_s;

    // Next-state, counter and fetch-buffer update logic.
    always_comb begin
        state_d     = state_q;
        is_write_d  = is_write_q;
        line_d      = line_q;
        wait_cnt_d  = wait_cnt_q;
        beat_d      = beat_q;
        fetch_buf_d = fetch_buf_q;
        prot_err_d  = prot_err_q;
        mem_we_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.CacheBusRW == RW_BOTH) begin
                    prot_err_d = 1'b1;
                end else if (bus.CacheBusRW != RW_NONE) begin
                    line_d     = bus.CacheBusAdr[OFFSETLEN +: IDXW];
                    is_write_d = (bus.CacheBusRW == RW_WB);
                    wait_cnt_d = 4'(LATENCY);
                    state_d    = (LATENCY == 0) ? BEATS : WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                // Leave on the cycle the count would reach zero, giving exactly LATENCY wait cycles.
                if (wait_cnt_q <= 4'd1) begin
                    state_d = BEATS;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            BEATS: begin
                if (is_write_q) begin
                    mem_we_s = 1'b1;
                end else begin
                    fetch_buf_d[beat_q * WORDLEN +: WORDLEN] = mem_rdata_s;
                end
                if (beat_q == LOGBWPL'(N - 1)) begin
                    beat_d  = {LOGBWPL{1'b0}};
                    state_d = ACK;
                end else begin
                    beat_d = beat_q + LOGBWPL'(1);
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; synchronous active-low reset leaves memory untouched.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            is_write_q  <= 1'b0;
            line_q      <= {IDXW{1'b0}};
            wait_cnt_q  <= 4'd0;
            beat_q      <= {LOGBWPL{1'b0}};
            fetch_buf_q <= {LINELEN{1'b0}};
            prot_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_write_q  <= is_write_d;
            line_q      <= line_d;
            wait_cnt_q  <= wait_cnt_d;
            beat_q      <= beat_d;
            fetch_buf_q <= fetch_buf_d;
            prot_err_q  <= prot_err_d;
        end
    end

    line_word_mem #(
        .AW      (IDXW + LOGBWPL),
        .WORDLEN (WORDLEN)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we_s),
        .addr  ({line_q, beat_q}),
        .wdata (bus.ReadDataWord),
        .rdata (mem_rdata_s)
    );

    // Upper address bits alias lines modulo NUMLINES_MEM; offset bits are zero for aligned requests.
    assign unused_adr_s = ^{bus.CacheBusAdr[PA_BITS-1:OFFSETLEN+IDXW], bus.CacheBusAdr[OFFSETLEN-1:0]};

    assign bus.CacheBusAck = (state_q == ACK);
    assign bus.SelBusBeat  = (state_q == BEATS) && is_write_q;
    assign bus.BeatCount   = beat_q;
    assign bus.FetchBuffer = fetch_buf_q;
    assign bus.ProtocolErr = prot_err_q;

endmodule
